// File: rtl/bump_avoid_pkg.sv
// Shared types for the bumper escape controller: state codes, side latch and
// the per-state motor command table {len, ldir, ren, rdir}.
package bump_avoid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_BACK   = 3'd2,
    ST_TURN_L = 3'd3,
    ST_TURN_R = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SIDE_LEFT  = 2'd0,
    SIDE_RIGHT = 2'd1,
    SIDE_BOTH  = 2'd2
  } side_e;

  localparam logic [3:0] MOT_IDLE   = 4'b0000;
  localparam logic [3:0] MOT_FWD    = 4'b1111;
  localparam logic [3:0] MOT_BACK   = 4'b1010;
  localparam logic [3:0] MOT_TURN_L = 4'b1011;
  localparam logic [3:0] MOT_TURN_R = 4'b1110;
  localparam logic [3:0] MOT_HALT   = 4'b0000;

  function automatic logic [3:0] motor_cmd(input logic [2:0] st);
    logic [3:0] cmd;
    case (st)
      ST_IDLE:   cmd = MOT_IDLE;
      ST_FWD:    cmd = MOT_FWD;
      ST_BACK:   cmd = MOT_BACK;
      ST_TURN_L: cmd = MOT_TURN_L;
      ST_TURN_R: cmd = MOT_TURN_R;
      ST_HALT:   cmd = MOT_HALT;
      default:   cmd = MOT_IDLE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/bump_avoid_if.sv
// Control/command bundle between the bumper controller and its environment.
interface bump_avoid_if #(
  parameter int RETRY_W = 2
);
  logic               tick;
  logic               enable;
  logic               l_bumper_n;
  logic               r_bumper_n;
  logic               len;
  logic               ldir;
  logic               ren;
  logic               rdir;
  logic [2:0]         state;
  logic               halted;
  logic [RETRY_W-1:0] bump_count;

  modport master (
    output tick, enable, l_bumper_n, r_bumper_n,
    input  len, ldir, ren, rdir, state, halted, bump_count
  );

  modport slave (
    input  tick, enable, l_bumper_n, r_bumper_n,
    output len, ldir, ren, rdir, state, halted, bump_count
  );
endinterface

// File: rtl/bump_avoid_ctrl_debounce.sv
// Two-flop synchroniser plus debounce for one active-low bumper; the pressed
// level flips only after DEB_CYCLES consecutive disagreeing synchronised samples.
module bumper_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic pressed
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_cnt;
  logic          r_pressed;
  logic          w_sync_pressed;

  assign w_sync_pressed = ~r_sync2;

  // synchroniser chain and disagreement counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= {DW{1'b0}};
      r_pressed <= 1'b0;
    end else begin
      r_sync1 <= raw_n;
      r_sync2 <= r_sync1;
      if (w_sync_pressed != r_pressed) begin
        if (r_cnt == CNT_LAST) begin
          r_pressed <= w_sync_pressed;
          r_cnt     <= {DW{1'b0}};
        end else begin
          r_cnt <= r_cnt + {{(DW-1){1'b0}}, 1'b1};
        end
      end else begin
        r_cnt <= {DW{1'b0}};
      end
    end
  end

  assign pressed = r_pressed;
endmodule

// File: rtl/bump_avoid_ctrl.sv
// Bumper-driven drive controller: forward until a debounced bump, back up,
// turn away from the bump, and halt after MAX_RETRY bumps without a clear.
module bump_avoid_ctrl
  import bump_avoid_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEB_CYCLES  = 4,
  parameter int BACK_TICKS  = 1000,
  parameter int TURN_TICKS  = 500,
  parameter int CLEAR_TICKS = 4000,
  parameter int MAX_RETRY   = 3
) (
  input logic         clk,
  input logic         reset,
  bump_avoid_if.slave bus
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]   T_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   LD_BACK  = CNT_W'(BACK_TICKS - 1);
  localparam logic [CNT_W-1:0]   LD_TURN  = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0]   LD_TURN2 = CNT_W'(2 * TURN_TICKS - 1);
  localparam logic [CNT_W-1:0]   LD_CLEAR = CNT_W'(CLEAR_TICKS - 1);
  localparam logic [RETRY_W-1:0] CNT_MAX  = RETRY_W'(MAX_RETRY);

  logic [2:0]         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_timer, w_timer_nxt, w_timer_dec;
  logic [RETRY_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  side_e              r_side, w_side_nxt, w_side_now;
  logic               w_l_pressed, w_r_pressed, w_timeout;
  logic [3:0]         w_mot;
  logic               w_halted;

  bumper_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk(clk), .reset(reset), .raw_n(bus.l_bumper_n), .pressed(w_l_pressed)
  );
  bumper_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk(clk), .reset(reset), .raw_n(bus.r_bumper_n), .pressed(w_r_pressed)
  );

  assign w_timeout   = bus.tick && (r_timer == T_ZERO);
  assign w_timer_dec = r_timer - {{(CNT_W-1){1'b0}}, bus.tick};
  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + {{(RETRY_W-1){1'b0}}, 1'b1};
  // a left hit means escape to the right; a double hit also turns right
  assign w_side_now  = (w_l_pressed && w_r_pressed) ? SIDE_BOTH :
                       (w_l_pressed ? SIDE_LEFT : SIDE_RIGHT);

  // state, timer, retry counter and side latch registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_timer <= T_ZERO;
      r_cnt   <= {RETRY_W{1'b0}};
      r_side  <= SIDE_LEFT;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_cnt   <= w_cnt_nxt;
      r_side  <= w_side_nxt;
    end
  end

  // next-state, timer and counter decisions in priority order
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_cnt_nxt   = r_cnt;
    w_side_nxt  = r_side;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = T_ZERO;
      w_cnt_nxt   = {RETRY_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_FWD;
          w_timer_nxt = LD_CLEAR;
        end
        ST_FWD: begin
          if (w_l_pressed || w_r_pressed) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) begin
              w_state_nxt = ST_HALT;
              w_timer_nxt = T_ZERO;
            end else begin
              w_state_nxt = ST_BACK;
              w_timer_nxt = LD_BACK;
              w_side_nxt  = w_side_now;
            end
          end else if (w_timeout) begin
            // timer stays at zero so the count is re-cleared on every tick
            w_cnt_nxt = {RETRY_W{1'b0}};
          end else begin
            w_timer_nxt = w_timer_dec;
          end
        end
        ST_BACK: begin
          if (w_timeout) begin
            if (r_side == SIDE_RIGHT) begin
              w_state_nxt = ST_TURN_L;
              w_timer_nxt = LD_TURN;
            end else begin
              w_state_nxt = ST_TURN_R;
              w_timer_nxt = (r_side == SIDE_BOTH) ? LD_TURN2 : LD_TURN;
            end
          end else begin
            w_timer_nxt = w_timer_dec;
          end
        end
        ST_TURN_L, ST_TURN_R: begin
          if (w_timeout) begin
            w_state_nxt = ST_FWD;
            w_timer_nxt = LD_CLEAR;
          end else begin
            w_timer_nxt = w_timer_dec;
          end
        end
        ST_HALT: begin
          w_state_nxt = ST_HALT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = T_ZERO;
        end
      endcase
    end
  end

  // Moore decode of the state register
  always_comb begin
    w_mot    = motor_cmd(r_state);
    w_halted = (r_state == ST_HALT);
  end

  assign bus.len        = w_mot[3];
  assign bus.ldir       = w_mot[2];
  assign bus.ren        = w_mot[1];
  assign bus.rdir       = w_mot[0];
  assign bus.state      = r_state;
  assign bus.halted     = w_halted;
  assign bus.bump_count = r_cnt;
endmodule
